fmul_mant_seq: RTL

Iterative mantissa-multiply sequencer for the floating-point multiplier (F_Mul). It accepts two unsigned W-bit mantissas and generates AND-based partial products two per cycle. It reduces them into a carry-save accumulator through one shared `compressor42_gold` instance, then resolves sum + carry with one final add. It sits between F_Mul's operand-unpack stage and its normalize/round stage, trading latency for area against a full compressor tree.

---
 rtl/fmul_pkg.sv | 22 ++
 rtl/compressor42_gold.sv | 42 ++++
 rtl/fmul_mant_seq.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/fmul_pkg.sv
// fmul_pkg -- shared definitions for the F_Mul mantissa path.
//   fmul_seq_state_t : sequencer states (IDLE, REDUCE, ADD, DONE)
//   FMUL_MANT_W      : default mantissa width including the hidden bit
//   FMUL_PAIRS       : partial-product pairs for the default width
//   fmul_pairs()     : pair count for an arbitrary even width
package fmul_pkg;

   localparam int FMUL_MANT_W = 24;
   localparam int FMUL_PAIRS  = FMUL_MANT_W / 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REDUCE = 2'd1,
      ADD    = 2'd2,
      DONE   = 2'd3
   } fmul_seq_state_t;

   function automatic int fmul_pairs(input int w);
      return w / 2;
   endfunction

endpackage

// File: rtl/compressor42_gold.sv
// compressor42_gold -- bit-parallel 4:2 compressor over 2*length bits.
//   in1..in4 [2L-1:0] : addends
//   cin               : carry into bit 0 of the second full-adder row
//   out2 [2L:0]       : sum vector (bit 2L holds the first-row top carry)
//   out1 [2L:0]       : carry vector, weight 2 (bit 2L is always 0)
//   cout              : first-row carry out of the top bit
// Identity: in1+in2+in3+in4+cin == out2 + 2*out1 (exact, no overflow).
module compressor42_gold #(
   parameter int length = 24
) (
   input  logic [2*length-1:0] in1,
   input  logic [2*length-1:0] in2,
   input  logic [2*length-1:0] in3,
   input  logic [2*length-1:0] in4,
   input  logic                cin,
   output logic [2*length:0]   out1,
   output logic [2*length:0]   out2,
   output logic                cout
);

   localparam int N = 2 * length;

   logic [N-1:0] s1;
   logic [N-1:0] c1;
   logic [N-1:0] ci;
   logic [N-1:0] sum_v;
   logic [N-1:0] cy_v;

   // First row: 3:2 over in1..in3.
   assign s1 = in1 ^ in2 ^ in3;
   assign c1 = (in1 & in2) | (in1 & in3) | (in2 & in3);

   // Second row: first-row carries move up one bit and meet in4.
   assign ci    = {c1[N-2:0], cin};
   assign sum_v = s1 ^ in4 ^ ci;
   assign cy_v  = (s1 & in4) | (s1 & ci) | (in4 & ci);

   assign out2 = {c1[N-1], sum_v};
   assign out1 = {1'b0, cy_v};
   assign cout = c1[N-1];

endmodule

// File: rtl/fmul_mant_seq.sv
// fmul_mant_seq -- iterative W x W mantissa multiplier for F_Mul.
// Two AND partial products per cycle are folded into a carry-save
// accumulator through one shared 4:2 compressor; a final add resolves it.
// Ports:
//   CLK, RST          : clock, synchronous active-high reset
//   flush             : synchronous abort back to IDLE
//   in_valid/in_ready : operand handshake (mant_a, mant_b)
//   out_valid/out_ready: product handshake (product, 2W bits)
//   busy              : high in REDUCE and ADD
//   dbg_state         : current sequencer state
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; a producer holds valid and data stable until that edge.
// Option: FMUL_ZERO_SKIP_EN -- zero operand goes straight to DONE with 0.
import fmul_pkg::*;

module fmul_mant_seq #(
   parameter int W     = FMUL_MANT_W,
   parameter int CNT_W = 4
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [W-1:0]    mant_a,
   input  logic [W-1:0]    mant_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [2*W-1:0]  product,
   output logic            busy,
   output fmul_seq_state_t dbg_state
);

   localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'(fmul_pairs(W) - 1);

   fmul_seq_state_t state_q, state_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     b_q, b_d;
   logic [2*W-1:0]   sum_q, sum_d;
   logic [2*W-1:0]   carry_q, carry_d;
   logic [2*W-1:0]   prod_q, prod_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Partial-product pair selected by cnt_q: rows 2k and 2k+1.
   logic [CNT_W:0]   shamt_lo, shamt_hi;
   logic [2*W-1:0]   a_ext, pp_lo, pp_hi;
   logic [2*W:0]     cmp_out1, cmp_out2;
   logic             cmp_cout_unused;
   logic             top_bits_unused;

   assign shamt_lo = {cnt_q, 1'b0};
   assign shamt_hi = {cnt_q, 1'b1};
   assign a_ext    = {{W{1'b0}}, a_q};
   assign pp_lo    = b_q[shamt_lo] ? (a_ext << shamt_lo) : '0;
   assign pp_hi    = b_q[shamt_hi] ? (a_ext << shamt_hi) : '0;

   compressor42_gold #(.length(W)) u_cmp (
      .in1  (sum_q),
      .in2  (carry_q << 1),
      .in3  (pp_lo),
      .in4  (pp_hi),
      .cin  (1'b0),
      .out1 (cmp_out1),
      .out2 (cmp_out2),
      .cout (cmp_cout_unused)
   );

   // The product fits in 2W bits, so the compressor's top bits carry nothing.
   assign top_bits_unused = cmp_out1[2*W] ^ cmp_out2[2*W] ^ cmp_cout_unused;

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      sum_d     = sum_q;
      carry_d   = carry_q;
      prod_d    = prod_q;
      cnt_d     = cnt_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;

      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid && !flush) begin
               a_d     = mant_a;
               b_d     = mant_b;
               sum_d   = '0;
               carry_d = '0;
               cnt_d   = '0;
               state_d = REDUCE;
`ifdef FMUL_ZERO_SKIP_EN
               if (mant_a == '0 || mant_b == '0) begin
                  prod_d  = '0;
                  state_d = DONE;
               end
`else
`endif
            end
         end
         REDUCE: begin
            busy    = 1'b1;
            sum_d   = cmp_out2[2*W-1:0];
            carry_d = cmp_out1[2*W-1:0];
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST_PAIR) state_d = ADD;
         end
         ADD: begin
            busy    = 1'b1;
            prod_d  = sum_q + (carry_q << 1);
            state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Abort wins over everything; the held product is left untouched.
      if (flush) begin
         state_d = IDLE;
         prod_d  = prod_q;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= '0;
         prod_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         prod_q  <= prod_d;
         cnt_q   <= cnt_d;
      end
   end

   assign product   = prod_q;
   assign dbg_state = state_q;

endmodule
